// File: rtl/writeback.sv
// Writeback stage: registers the memory-stage result and commits it,
// or takes a trap (interrupt or exception) in its place.
module writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [31:0] rd_data_in,
    input  logic        csr_write_in,
    input  logic [11:0] csr_addr_in,
    input  logic [31:0] csr_data_in,
    input  logic        mret_in,
    input  logic        exception_in,
    input  logic [3:0]  exception_cause_in,
    input  logic        eip,
    input  logic        tip,
    input  logic        sip,
    output logic        reg_write,
    output logic [4:0]  reg_addr,
    output logic [31:0] reg_data,
    output logic        write_enable,
    output logic [11:0] write_address,
    output logic [31:0] write_data,
    output logic        retired,
    output logic        traped,
    output logic        mret,
    output logic [31:0] ecp,
    output logic [3:0]  trap_cause,
    output logic        interupt,
    output logic        flush,
    output logic        redirect_trap,
    output logic        redirect_mret
);

    logic        valid_d,           valid_q;
    logic [31:0] pc_d,              pc_q;
    logic [31:0] next_pc_d,         next_pc_q;
    logic [4:0]  rd_addr_d,         rd_addr_q;
    logic [31:0] rd_data_d,         rd_data_q;
    logic        csr_write_d,       csr_write_q;
    logic [11:0] csr_addr_d,        csr_addr_q;
    logic [31:0] csr_data_d,        csr_data_q;
    logic        mret_d,            mret_q;
    logic        exception_d,       exception_q;
    logic [3:0]  exception_cause_d, exception_cause_q;

    // A redirect this cycle makes whatever arrives next a wrong-path op.
    always_comb begin
        valid_d           = valid_in & ~flush;
        pc_d              = pc_in;
        next_pc_d         = next_pc_in;
        rd_addr_d         = rd_addr_in;
        rd_data_d         = rd_data_in;
        csr_write_d       = csr_write_in;
        csr_addr_d        = csr_addr_in;
        csr_data_d        = csr_data_in;
        mret_d            = mret_in;
        exception_d       = exception_in;
        exception_cause_d = exception_cause_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q              <= pc_d;
        next_pc_q         <= next_pc_d;
        rd_addr_q         <= rd_addr_d;
        rd_data_q         <= rd_data_d;
        csr_write_q       <= csr_write_d;
        csr_addr_q        <= csr_addr_d;
        csr_data_q        <= csr_data_d;
        mret_q            <= mret_d;
        exception_q       <= exception_d;
        exception_cause_q <= exception_cause_d;
    end

    // Sequential PC travels with the instruction but nothing here consumes it.
    logic unused_next_pc;
    assign unused_next_pc = ^next_pc_q;

    logic irq;
    assign irq = eip | sip | tip;

    always_comb begin
        reg_write     = 1'b0;
        reg_addr      = '0;
        reg_data      = '0;
        write_enable  = 1'b0;
        write_address = '0;
        write_data    = '0;
        retired       = 1'b0;
        traped        = 1'b0;
        mret          = 1'b0;
        ecp           = '0;
        trap_cause    = '0;
        interupt      = 1'b0;
        if (valid_q) begin
            if (irq) begin
                traped   = 1'b1;
                interupt = 1'b1;
                ecp      = pc_q;
                if (eip) begin
                    trap_cause = 4'd11;
                end else if (sip) begin
                    trap_cause = 4'd3;
                end else begin
                    trap_cause = 4'd7;
                end
            end else if (exception_q) begin
                traped     = 1'b1;
                ecp        = pc_q;
                trap_cause = exception_cause_q;
            end else begin
                retired = 1'b1;
                mret    = mret_q;
                if (rd_addr_q != 5'd0) begin
                    reg_write = 1'b1;
                    reg_addr  = rd_addr_q;
                    reg_data  = rd_data_q;
                end
                if (csr_write_q) begin
                    write_enable  = 1'b1;
                    write_address = csr_addr_q;
                    write_data    = csr_data_q;
                end
            end
        end
    end

    assign flush         = traped | mret;
    assign redirect_trap = traped;
    assign redirect_mret = mret & ~traped;

endmodule

// File: tb/tb_writeback.sv
// Directed vector bench for the writeback stage: table of per-cycle
// instructions and interrupt levels, plus an asynchronous reset sequence.
module tb_writeback;

    logic        clk;
    logic        reset;
    logic        valid_in;
    logic [31:0] pc_in;
    logic [31:0] next_pc_in;
    logic [4:0]  rd_addr_in;
    logic [31:0] rd_data_in;
    logic        csr_write_in;
    logic [11:0] csr_addr_in;
    logic [31:0] csr_data_in;
    logic        mret_in;
    logic        exception_in;
    logic [3:0]  exception_cause_in;
    logic        eip, tip, sip;
    logic        reg_write;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        write_enable;
    logic [11:0] write_address;
    logic [31:0] write_data;
    logic        retired, traped, mret;
    logic [31:0] ecp;
    logic [3:0]  trap_cause;
    logic        interupt, flush, redirect_trap, redirect_mret;

    writeback dut (
        .clk                (clk),
        .reset              (reset),
        .valid_in           (valid_in),
        .pc_in              (pc_in),
        .next_pc_in         (next_pc_in),
        .rd_addr_in         (rd_addr_in),
        .rd_data_in         (rd_data_in),
        .csr_write_in       (csr_write_in),
        .csr_addr_in        (csr_addr_in),
        .csr_data_in        (csr_data_in),
        .mret_in            (mret_in),
        .exception_in       (exception_in),
        .exception_cause_in (exception_cause_in),
        .eip                (eip),
        .tip                (tip),
        .sip                (sip),
        .reg_write          (reg_write),
        .reg_addr           (reg_addr),
        .reg_data           (reg_data),
        .write_enable       (write_enable),
        .write_address      (write_address),
        .write_data         (write_data),
        .retired            (retired),
        .traped             (traped),
        .mret               (mret),
        .ecp                (ecp),
        .trap_cause         (trap_cause),
        .interupt           (interupt),
        .flush              (flush),
        .redirect_trap      (redirect_trap),
        .redirect_mret      (redirect_mret)
    );

    typedef struct packed {
        logic        rw;
        logic [4:0]  ra;
        logic [31:0] rdat;
        logic        we;
        logic [11:0] wa;
        logic [31:0] wd;
        logic        ret;
        logic        trp;
        logic        mr;
        logic [31:0] ecp;
        logic [3:0]  cause;
        logic        intr;
        logic        fl;
        logic        rt;
        logic        rm;
    } out_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] rdat;
        logic        cw;
        logic [11:0] ca;
        logic [31:0] cd;
        logic        mr;
        logic        ex;
        logic [3:0]  cause;
        logic [2:0]  irq;
        out_t        exp;
    } vec_t;

    out_t act;
    assign act = {reg_write, reg_addr, reg_data,
                  write_enable, write_address, write_data,
                  retired, traped, mret, ecp, trap_cause,
                  interupt, flush, redirect_trap, redirect_mret};

    int checks = 0;
    int errors = 0;
    vec_t tbl [16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t e_zero();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t e_commit(input logic [4:0] rd,
                                      input logic [31:0] d,
                                      input logic cw,
                                      input logic [11:0] a,
                                      input logic [31:0] wd,
                                      input logic mr);
        out_t o = '0;
        o.ret = 1'b1;
        if (rd != 5'd0) begin
            o.rw = 1'b1; o.ra = rd; o.rdat = d;
        end
        if (cw) begin
            o.we = 1'b1; o.wa = a; o.wd = wd;
        end
        o.mr = mr; o.fl = mr; o.rm = mr;
        return o;
    endfunction

    function automatic out_t e_trap(input logic [31:0] pc,
                                    input logic [3:0] cause,
                                    input logic intr);
        out_t o = '0;
        o.trp = 1'b1; o.ecp = pc; o.cause = cause;
        o.intr = intr; o.fl = 1'b1; o.rt = 1'b1;
        return o;
    endfunction

    function automatic vec_t mkv(input logic v, input logic [31:0] pc,
                                 input logic [4:0] rd, input logic [31:0] rdat,
                                 input logic cw, input logic [11:0] ca,
                                 input logic [31:0] cd, input logic mr,
                                 input logic ex, input logic [3:0] cause,
                                 input logic [2:0] irq, input out_t exp);
        vec_t r;
        r.v = v; r.pc = pc; r.rd = rd; r.rdat = rdat;
        r.cw = cw; r.ca = ca; r.cd = cd; r.mr = mr;
        r.ex = ex; r.cause = cause; r.irq = irq; r.exp = exp;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        valid_in           = t.v;
        pc_in              = t.pc;
        next_pc_in         = t.pc + 32'd4;
        rd_addr_in         = t.rd;
        rd_data_in         = t.rdat;
        csr_write_in       = t.cw;
        csr_addr_in        = t.ca;
        csr_data_in        = t.cd;
        mret_in            = t.mr;
        exception_in       = t.ex;
        exception_cause_in = t.cause;
    endtask

    task automatic chk(input string name, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    initial begin
        // irq field is {eip, sip, tip}; it applies while that row is registered
        tbl[0]  = mkv(1, 32'h100, 5, 32'hDEADBEEF, 0, 12'h0, 0, 0, 0, 0, 3'b000,
                      e_commit(5, 32'hDEADBEEF, 0, 12'h0, 0, 0));
        tbl[1]  = mkv(1, 32'h104, 0, 32'h1234, 1, 12'h340, 32'h55, 0, 0, 0, 3'b000,
                      e_commit(0, 0, 1, 12'h340, 32'h55, 0));
        tbl[2]  = mkv(1, 32'h200, 7, 32'h1, 0, 12'h0, 0, 0, 1, 4'd2, 3'b000,
                      e_trap(32'h200, 4'd2, 0));
        tbl[3]  = mkv(1, 32'h204, 3, 32'h9, 0, 12'h0, 0, 0, 0, 0, 3'b000,
                      e_zero());
        tbl[4]  = mkv(1, 32'h300, 6, 32'h6, 0, 12'h0, 0, 0, 1, 4'd5, 3'b101,
                      e_trap(32'h300, 4'd11, 1));
        tbl[5]  = mkv(1, 32'h304, 6, 32'h6, 0, 12'h0, 0, 0, 0, 0, 3'b000,
                      e_zero());
        tbl[6]  = mkv(1, 32'h400, 8, 32'h12, 0, 12'h0, 0, 0, 0, 0, 3'b001,
                      e_trap(32'h400, 4'd7, 1));
        tbl[7]  = mkv(1, 32'h404, 8, 32'h12, 0, 12'h0, 0, 0, 0, 0, 3'b000,
                      e_zero());
        tbl[8]  = mkv(0, 32'h408, 8, 32'h12, 0, 12'h0, 0, 0, 0, 0, 3'b100,
                      e_zero());
        tbl[9]  = mkv(1, 32'h500, 1, 32'hAA, 0, 12'h0, 0, 0, 0, 0, 3'b011,
                      e_trap(32'h500, 4'd3, 1));
        tbl[10] = mkv(1, 32'h504, 1, 32'hAA, 0, 12'h0, 0, 0, 0, 0, 3'b000,
                      e_zero());
        tbl[11] = mkv(1, 32'h600, 0, 32'h0, 0, 12'h0, 0, 1, 0, 0, 3'b000,
                      e_commit(0, 0, 0, 12'h0, 0, 1));
        tbl[12] = mkv(1, 32'h604, 2, 32'h22, 0, 12'h0, 0, 0, 0, 0, 3'b000,
                      e_zero());
        tbl[13] = mkv(1, 32'h700, 31, 32'hFFFFFFFF, 1, 12'h305, 32'h80, 0, 0, 0, 3'b000,
                      e_commit(31, 32'hFFFFFFFF, 1, 12'h305, 32'h80, 0));
        tbl[14] = mkv(1, 32'h704, 4, 32'h44, 0, 12'h0, 0, 1, 1, 4'd3, 3'b000,
                      e_trap(32'h704, 4'd3, 0));
        tbl[15] = mkv(0, 32'h708, 4, 32'h44, 0, 12'h0, 0, 0, 0, 0, 3'b001,
                      e_zero());

        reset = 1'b1;
        {eip, sip, tip} = 3'b000;
        drive(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, e_zero()));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", e_zero());
        eip = 1'b1;
        #1;
        chk("reset_irq", e_zero());
        eip = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i]);
            @(posedge clk);
            #1;
            {eip, sip, tip} = tbl[i].irq;
            #1;
            chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        drive(mkv(1, 32'h800, 4, 32'h44, 0, 0, 0, 0, 0, 0, 3'b000, e_zero()));
        @(posedge clk);
        #1;
        {eip, sip, tip} = 3'b000;
        #1;
        chk("pre_reset", e_commit(4, 32'h44, 0, 12'h0, 0, 0));
        reset = 1'b1;
        #1;
        chk("async_reset", e_zero());
        drive(mkv(1, 32'h808, 5, 32'h55, 0, 0, 0, 0, 0, 0, 3'b000, e_zero()));
        @(posedge clk);
        #1;
        chk("reset_hold", e_zero());
        reset = 1'b0;
        drive(mkv(1, 32'h900, 9, 32'h99, 0, 0, 0, 0, 0, 0, 3'b000, e_zero()));
        @(posedge clk);
        #2;
        chk("post_reset", e_commit(9, 32'h99, 0, 12'h0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
